// File: rtl/gemm_stream_adapter.sv
// Streaming front/back end for the GEMM butterfly engine. Four complex SFP samples are
// packed into one issue; the results are captured after GEMM_LAT cycles and serialised back out.
module gemm_stream_adapter #(
    parameter int EXP_WIDTH = 4,
    parameter int SIG_WIDTH = 4,
    parameter int FMT_WIDTH = 1 + EXP_WIDTH + SIG_WIDTH,
    parameter int GEMM_LAT  = 4,
    parameter int RES_DEPTH = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mode,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [FMT_WIDTH-1:0]   in_real,
    input  logic [FMT_WIDTH-1:0]   in_imag,
    output logic                   gemm_start,
    output logic                   gemm_control,
    output logic [4*FMT_WIDTH-1:0] gemm_in_real,
    output logic [4*FMT_WIDTH-1:0] gemm_in_imag,
    input  logic [4*FMT_WIDTH-1:0] gemm_out_real,
    input  logic [4*FMT_WIDTH-1:0] gemm_out_imag,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FMT_WIDTH-1:0]   out_real,
    output logic [FMT_WIDTH-1:0]   out_imag,
    output logic                   out_last,
    output logic                   busy
);

    localparam int PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;
    localparam int CW = $clog2(RES_DEPTH + 1);
    localparam logic [CW:0] DEPTH_C = (CW + 1)'(RES_DEPTH);

    logic [2:0]           r_fill;
    logic                 r_control;
    logic [FMT_WIDTH-1:0] r_lane_real [4];
    logic [FMT_WIDTH-1:0] r_lane_imag [4];
    logic [GEMM_LAT-1:0]  r_iss_vld_p;
    logic [CW-1:0]        r_inflight;
    logic [CW-1:0]        r_res_count;
    logic [PW-1:0]        r_wr_ptr;
    logic [PW-1:0]        r_rd_ptr;
    logic [1:0]           r_lane_ptr;
    logic [FMT_WIDTH-1:0] r_buf_real [RES_DEPTH][4];
    logic [FMT_WIDTH-1:0] r_buf_imag [RES_DEPTH][4];

    logic       w_accept;
    logic       w_credit_ok;
    logic       w_issue;
    logic       w_capture;
    logic       w_out_fire;
    logic       w_pop;
    logic [1:0] w_wr_lane;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(RES_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign in_ready    = (r_fill < 3'd4);
    assign w_accept    = in_valid & in_ready;
    // Credit counts groups already buffered plus groups still inside GEMM; a same-cycle pop is not credited.
    assign w_credit_ok = ({1'b0, r_res_count} + {1'b0, r_inflight}) < DEPTH_C;
    assign w_issue     = (r_fill == 3'd4) && w_credit_ok;
    assign w_capture   = r_iss_vld_p[GEMM_LAT-1];
    assign out_valid   = (r_res_count != '0);
    assign w_out_fire  = out_valid & out_ready;
    assign w_pop       = w_out_fire & (r_lane_ptr == 2'd0);
    assign w_wr_lane   = ~r_fill[1:0];

    assign gemm_start   = w_issue;
    assign gemm_control = r_control;
    assign gemm_in_real = {r_lane_real[3], r_lane_real[2], r_lane_real[1], r_lane_real[0]};
    assign gemm_in_imag = {r_lane_imag[3], r_lane_imag[2], r_lane_imag[1], r_lane_imag[0]};

    assign out_real = out_valid ? r_buf_real[r_rd_ptr][r_lane_ptr] : '0;
    assign out_imag = out_valid ? r_buf_imag[r_rd_ptr][r_lane_ptr] : '0;
    assign out_last = out_valid & (r_lane_ptr == 2'd0);
    assign busy     = (r_fill != 3'd0) | (r_inflight != '0) | (r_res_count != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fill      <= '0;
            r_control   <= 1'b0;
            r_iss_vld_p <= '0;
            r_inflight  <= '0;
            r_res_count <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_lane_ptr  <= 2'd3;
            for (int i = 0; i < 4; i++) begin
                r_lane_real[i] <= '0;
                r_lane_imag[i] <= '0;
            end
        end else begin
            // Assembly: k-th accepted sample lands in lane 3-k.
            if (w_accept) begin
                r_lane_real[w_wr_lane] <= in_real;
                r_lane_imag[w_wr_lane] <= in_imag;
                if (r_fill == 3'd0) begin
                    r_control <= mode;
                end
            end
            if (w_issue) begin
                r_fill <= '0;
            end else if (w_accept) begin
                r_fill <= r_fill + 1'b1;
            end

            // Issue tracking across the fixed GEMM latency.
            r_iss_vld_p[0] <= w_issue;
            for (int i = 1; i < GEMM_LAT; i++) begin
                r_iss_vld_p[i] <= r_iss_vld_p[i-1];
            end
            case ({w_issue, w_capture})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase

            // Result buffer bookkeeping and serialisation.
            case ({w_capture, w_pop})
                2'b10:   r_res_count <= r_res_count + 1'b1;
                2'b01:   r_res_count <= r_res_count - 1'b1;
                default: r_res_count <= r_res_count;
            endcase
            if (w_capture) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            if (w_out_fire) begin
                r_lane_ptr <= r_lane_ptr - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture) begin
            for (int i = 0; i < 4; i++) begin
                r_buf_real[r_wr_ptr][i] <= gemm_out_real[i*FMT_WIDTH +: FMT_WIDTH];
                r_buf_imag[r_wr_ptr][i] <= gemm_out_imag[i*FMT_WIDTH +: FMT_WIDTH];
            end
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
        !(w_capture && (r_res_count == DEPTH_C[CW-1:0])));

endmodule

// File: tb/tb_gemm_stream_adapter.sv
// Directed table vectors plus multi-cycle sequences for gemm_stream_adapter, with an
// echoing GEMM stub that only returns real data on the cycle the result is due.
module tb_gemm_stream_adapter;
    localparam int FW  = 9;
    localparam int LAT = 4;
    localparam int RD  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          mode;
    logic          in_valid;
    logic          in_ready;
    logic [FW-1:0] in_real;
    logic [FW-1:0] in_imag;
    logic          gemm_start;
    logic          gemm_control;
    logic [4*FW-1:0] gemm_in_real;
    logic [4*FW-1:0] gemm_in_imag;
    logic [4*FW-1:0] gemm_out_real;
    logic [4*FW-1:0] gemm_out_imag;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] out_real;
    logic [FW-1:0] out_imag;
    logic          out_last;
    logic          busy;

    always #5 clk = ~clk;

    gemm_stream_adapter #(.EXP_WIDTH(4), .SIG_WIDTH(4), .FMT_WIDTH(FW), .GEMM_LAT(LAT), .RES_DEPTH(RD)) dut (
        .clk(clk), .rst(rst), .mode(mode), .in_valid(in_valid), .in_ready(in_ready),
        .in_real(in_real), .in_imag(in_imag), .gemm_start(gemm_start), .gemm_control(gemm_control),
        .gemm_in_real(gemm_in_real), .gemm_in_imag(gemm_in_imag),
        .gemm_out_real(gemm_out_real), .gemm_out_imag(gemm_out_imag),
        .out_valid(out_valid), .out_ready(out_ready), .out_real(out_real), .out_imag(out_imag),
        .out_last(out_last), .busy(busy)
    );

    // GEMM stub: echoes the issued lanes LAT cycles later, garbage on any other cycle.
    logic [4*FW-1:0] st_re [LAT];
    logic [4*FW-1:0] st_im [LAT];
    logic [LAT-1:0]  st_v = '0;
    always @(posedge clk) begin
        st_re[0] <= gemm_in_real;
        st_im[0] <= gemm_in_imag;
        st_v[0]  <= gemm_start;
        for (int i = 1; i < LAT; i++) begin
            st_re[i] <= st_re[i-1];
            st_im[i] <= st_im[i-1];
            st_v[i]  <= st_v[i-1];
        end
    end
    assign gemm_out_real = st_v[LAT-1] ? st_re[LAT-1] : {4{9'h1A5}};
    assign gemm_out_imag = st_v[LAT-1] ? st_im[LAT-1] : {4{9'h05A}};

    int n_tests = 0;
    int n_fail  = 0;

    function automatic void chk(string nm, logic [63:0] act, logic [63:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp_v);
        end
    endfunction

    // Scoreboard state
    logic [FW-1:0]   feed_re [$];
    logic [FW-1:0]   feed_im [$];
    logic            feed_mode [$];
    logic [2*FW-1:0] exp_q [$];
    int feed_idx, n_start, out_cnt, cyc, first_pop_cyc, third_start_cyc;
    logic prev_start, prev_mode;

    task automatic clear_sb();
        feed_re.delete(); feed_im.delete(); feed_mode.delete(); exp_q.delete();
        feed_idx = 0; n_start = 0; out_cnt = 0; cyc = -1;
        first_pop_cyc = -100; third_start_cyc = -1;
        prev_start = 1'b0; prev_mode = 1'b0;
    endtask

    task automatic add_group(input logic m, input logic [FW-1:0] r0, r1, r2, r3,
                             input logic [FW-1:0] i0, i1, i2, i3);
        feed_mode.push_back(m);
        feed_re.push_back(r0); feed_re.push_back(r1); feed_re.push_back(r2); feed_re.push_back(r3);
        feed_im.push_back(i0); feed_im.push_back(i1); feed_im.push_back(i2); feed_im.push_back(i3);
    endtask

    task automatic add_rand_group(input logic m);
        add_group(m, FW'($urandom), FW'($urandom), FW'($urandom), FW'($urandom),
                  FW'($urandom), FW'($urandom), FW'($urandom), FW'($urandom));
    endtask

    // One clock cycle: drive at the falling edge, observe 1 ns later, well before the rising edge.
    task automatic step(input bit tv, input bit rdy);
        int g;
        logic [2*FW-1:0] e;
        @(negedge clk);
        if (tv && feed_idx < feed_re.size()) begin
            in_valid = 1'b1;
            in_real  = feed_re[feed_idx];
            in_imag  = feed_im[feed_idx];
            mode     = (feed_idx % 4 == 0) ? feed_mode[feed_idx / 4] : 1'($urandom);
        end else begin
            in_valid = 1'b0;
            mode     = 1'($urandom);
        end
        out_ready = rdy;
        #1;
        cyc++;
        if (prev_start) chk("ctrl_hold", gemm_control, prev_mode);
        prev_start = gemm_start;
        if (gemm_start) begin
            g = n_start;
            n_start++;
            if (n_start == 3) third_start_cyc = cyc;
            if (g < feed_mode.size()) begin
                prev_mode = feed_mode[g];
                chk("ctrl_issue", gemm_control, feed_mode[g]);
                chk("pack_re", gemm_in_real, {feed_re[4*g], feed_re[4*g+1], feed_re[4*g+2], feed_re[4*g+3]});
                chk("pack_im", gemm_in_imag, {feed_im[4*g], feed_im[4*g+1], feed_im[4*g+2], feed_im[4*g+3]});
            end else begin
                chk("extra_start", n_start, feed_mode.size());
            end
        end
        if (in_valid && in_ready) begin
            exp_q.push_back({in_real, in_imag});
            feed_idx++;
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("spurious_out", exp_q.size(), 1);
            end else begin
                e = exp_q.pop_front();
                chk("out_data", {out_real, out_imag}, e);
                out_cnt++;
                chk("out_last", out_last, (out_cnt % 4 == 0));
                if (out_last && first_pop_cyc < 0) first_pop_cyc = cyc;
            end
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        chk({tag, "_start"}, gemm_start, 0);
        chk({tag, "_ctrl"}, gemm_control, 0);
        chk({tag, "_gin"}, {gemm_in_real, gemm_in_imag}, 0);
        chk({tag, "_ovalid"}, {out_valid, out_last}, 0);
        chk({tag, "_odata"}, {out_real, out_imag}, 0);
        chk({tag, "_busy"}, busy, 0);
    endtask

    typedef struct packed {
        logic            m;
        logic [FW-1:0]   r0, r1, r2, r3;
        logic [FW-1:0]   i0, i1, i2, i3;
        logic [4*FW-1:0] pre;
        logic [4*FW-1:0] pim;
    } vec_t;

    function automatic logic [2*FW-1:0] pick(input vec_t v, input int k);
        case (k)
            0:       return {v.r0, v.i0};
            1:       return {v.r1, v.i1};
            2:       return {v.r2, v.i2};
            default: return {v.r3, v.i3};
        endcase
    endfunction

    vec_t tv [5];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        logic [15:0]     v_start, v_valid, v_last, v_busy;
        logic [4*FW-1:0] got_re, got_im;
        logic            got_ctrl, any_v;
        logic [2*FW-1:0] got_o [4];
        logic [3:0]      got_last;
        logic [2*FW-1:0] snap;
        int              n_got;

        tv[0] = '{1'b1, 9'h001, 9'h002, 9'h003, 9'h004, 9'h000, 9'h000, 9'h000, 9'h000,
                  {9'h001, 9'h002, 9'h003, 9'h004}, 36'h0};
        tv[1] = '{1'b0, 9'h1FF, 9'h100, 9'h0AA, 9'h155, 9'h011, 9'h022, 9'h033, 9'h044,
                  {9'h1FF, 9'h100, 9'h0AA, 9'h155}, {9'h011, 9'h022, 9'h033, 9'h044}};
        tv[2] = '{1'b1, 9'h000, 9'h1FF, 9'h000, 9'h1FF, 9'h1FF, 9'h000, 9'h1FF, 9'h000,
                  {9'h000, 9'h1FF, 9'h000, 9'h1FF}, {9'h1FF, 9'h000, 9'h1FF, 9'h000}};
        tv[3] = '{1'b0, 9'h123, 9'h045, 9'h067, 9'h089, 9'h0AB, 9'h0CD, 9'h0EF, 9'h101,
                  {9'h123, 9'h045, 9'h067, 9'h089}, {9'h0AB, 9'h0CD, 9'h0EF, 9'h101}};
        tv[4] = '{1'b1, 9'h080, 9'h040, 9'h020, 9'h010, 9'h008, 9'h004, 9'h002, 9'h001,
                  {9'h080, 9'h040, 9'h020, 9'h010}, {9'h008, 9'h004, 9'h002, 9'h001}};

        rst = 1'b1; mode = 1'b0; in_valid = 1'b0; in_real = '0; in_imag = '0; out_ready = 1'b0;
        clear_sb();
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 check_reset("rst0");
        @(negedge clk) rst = 1'b1;

        // Cycle-exact timing of a single all-zero group, mode=1
        add_group(1'b1, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0, 9'h0);
        v_start = '0; v_valid = '0; v_last = '0; v_busy = '0;
        for (int c = 0; c < 16; c++) begin
            step(1'b1, 1'b1);
            v_start[c] = gemm_start;
            v_valid[c] = out_valid;
            v_last[c]  = out_last;
            v_busy[c]  = busy;
        end
        chk("t1_start_cycles", v_start, 16'h0010);
        chk("t1_valid_cycles", v_valid, 16'h1E00);
        chk("t1_last_cycles", v_last, 16'h1000);
        chk("t1_busy_cycles", v_busy, 16'h1FFE);
        chk("t1_out_count", out_cnt, 4);

        // Table-driven groups through the echo stub
        for (int i = 0; i < 5; i++) begin
            clear_sb();
            add_group(tv[i].m, tv[i].r0, tv[i].r1, tv[i].r2, tv[i].r3,
                      tv[i].i0, tv[i].i1, tv[i].i2, tv[i].i3);
            n_got = 0; got_re = '0; got_im = '0; got_ctrl = 1'bx; got_last = '0;
            for (int c = 0; c < 30 && n_got < 4; c++) begin
                step(1'b1, 1'b1);
                if (gemm_start) begin
                    got_re = gemm_in_real; got_im = gemm_in_imag; got_ctrl = gemm_control;
                end
                if (out_valid) begin
                    got_o[n_got]    = {out_real, out_imag};
                    got_last[n_got] = out_last;
                    n_got++;
                end
            end
            chk("tv_count", n_got, 4);
            chk("tv_pack_re", got_re, tv[i].pre);
            chk("tv_pack_im", got_im, tv[i].pim);
            chk("tv_ctrl", got_ctrl, tv[i].m);
            for (int k = 0; k < 4; k++) chk("tv_out", got_o[k], pick(tv[i], k));
            chk("tv_last", got_last, 4'b1000);
        end

        // Credit stall: three groups, downstream blocked
        repeat (3) step(1'b0, 1'b1);
        clear_sb();
        for (int g = 0; g < 3; g++) add_rand_group(1'($urandom));
        snap = '0;
        for (int c = 0; c < 40; c++) begin
            step(1'b1, 1'b0);
            if (c == 20) snap = {out_real, out_imag};
        end
        chk("bp_starts", n_start, 2);
        chk("bp_fed", feed_idx, 12);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        chk("bp_head", snap, {feed_re[0], feed_im[0]});
        chk("bp_hold", {out_real, out_imag}, snap);
        for (int c = 0; c < 80 && out_cnt < 12; c++) step(1'b1, 1'b1);
        chk("bp_drain", out_cnt, 12);
        chk("bp_third_issue", third_start_cyc, first_pop_cyc + 1);

        // Alternating mode per group
        repeat (3) step(1'b0, 1'b1);
        clear_sb();
        add_rand_group(1'b1); add_rand_group(1'b0); add_rand_group(1'b1);
        for (int c = 0; c < 80 && out_cnt < 12; c++) step(1'b1, 1'b1);
        chk("mode_starts", n_start, 3);
        chk("mode_outs", out_cnt, 12);

        // Reset two cycles after an issue
        repeat (3) step(1'b0, 1'b1);
        clear_sb();
        add_rand_group(1'b1);
        for (int c = 0; c < 20 && n_start < 1; c++) step(1'b1, 1'b1);
        chk("rst_issue_seen", n_start, 1);
        step(1'b0, 1'b1);
        step(1'b0, 1'b1);
        rst = 1'b0;
        #1 check_reset("rst_mid");
        repeat (2) @(negedge clk);
        rst = 1'b1;
        clear_sb();
        any_v = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step(1'b0, 1'b1);
            any_v = any_v | out_valid | busy;
        end
        chk("rst_no_capture", any_v, 0);
        add_rand_group(1'b0);
        for (int c = 0; c < 30 && out_cnt < 4; c++) step(1'b1, 1'b1);
        chk("rst_recover", out_cnt, 4);

        // Random handshake traffic, 200 groups
        repeat (3) step(1'b0, 1'b1);
        clear_sb();
        for (int g = 0; g < 200; g++) add_rand_group(1'($urandom));
        for (int c = 0; c < 20000 && out_cnt < 800; c++)
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        chk("rand_outs", out_cnt, 800);
        chk("rand_starts", n_start, 200);
        chk("rand_leftover", exp_q.size(), 0);
        step(1'b0, 1'b1);
        chk("rand_idle", busy, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/gemm_stream_adapter.md
Name: gemm_stream_adapter

Overview:
- Streaming front/back end for the GEMM butterfly engine.
- Accepts complex SFP samples one per handshake and packs four of them into a GEMM issue vector. It drives start/control, tracks the fixed GEMM pipeline latency and captures the four complex results.
- Results are re-serialised one complex sample per handshake.
- Issue is credit-gated so results are never dropped under downstream backpressure.

Parameters:
- EXP_WIDTH, 4, SFP exponent width (matches GEMM expWidth).
- SIG_WIDTH, 4, SFP mantissa width (matches GEMM sigWidth).
- FMT_WIDTH, 9, SFP word width = 1+EXP_WIDTH+SIG_WIDTH.
- GEMM_LAT, 4, cycles from GEMM input-valid cycle to GEMM output register valid.
- RES_DEPTH, 2, result buffer depth in groups (4 complex samples each); power of 2, ≥1.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- mode  in  1  1=size4 butterfly, 0=dual size2; sampled with first sample of each group
- in_valid  in  1  input sample valid
- in_ready  out  1  adapter can accept a sample
- in_real  in  FMT_WIDTH  input sample real part
- in_imag  in  FMT_WIDTH  input sample imag part
- gemm_start  out  1  one-cycle issue pulse
- gemm_control  out  1  GEMM control (size4/size2)
- gemm_in_real  out  4*FMT_WIDTH  packed lanes, lane3 at MSBs
- gemm_in_imag  out  4*FMT_WIDTH  packed lanes, lane3 at MSBs
- gemm_out_real  in  4*FMT_WIDTH  GEMM result, lane3 at MSBs
- gemm_out_imag  in  4*FMT_WIDTH  GEMM result, lane3 at MSBs
- out_valid  out  1  output sample valid
- out_ready  in  1  downstream accepts
- out_real  out  FMT_WIDTH  output sample real part
- out_imag  out  FMT_WIDTH  output sample imag part
- out_last  out  1  high on 4th (lane0) sample of a group
- busy  out  1  any sample in assembly, in flight or buffered

Behaviour:
- Reset (async, rst=0): fill=0, inflight=0, issue pipe cleared, result buffer empty, lane pointer=3.
  - Outputs at reset: in_ready=1, gemm_start=0, gemm_control=0, gemm_in_*=0, out_valid=0, out_last=0, out_real/imag=0, busy=0.
  - Reset mid-operation discards assembled, in-flight and buffered data; GEMM outputs arriving afterwards are never captured.

Assembly:
- fill counter 0..4; in_ready = (fill<4).
- Accept on in_valid&in_ready. The k-th accepted sample (k=0..3) is written to lane 3-k.
- On accept with fill==0, gemm_control <= mode. gemm_control is unchanged at all other times.

Issue:
- Condition: fill==4 && (res_count+inflight) < RES_DEPTH. A pop in the same cycle is not credited.
- In the issue cycle: gemm_start=1, and gemm_in_* present the assembled lanes; these are registers and stable that cycle.
- Next edge: fill<=0, inflight+1.
- Earliest issue is the cycle after the 4th accept, so throughput is one group per 5 cycles.
- gemm_control stays stable for ≥2 cycles after issue, since the next group's first accept is at t+1 and updates at t+2.
- gemm_in_* between issues are don't-care; the GEMM result for non-issue cycles is ignored.

Capture:
- GEMM_LAT-bit issue shift register.
- The GEMM result for an issue at cycle t is sampled at the end of cycle t+GEMM_LAT.
- On capture the group is pushed into the result buffer and inflight decrements.
- Capture and issue in the same cycle: inflight unchanged. Capture and pop in the same cycle: res_count unchanged.
- Overflow is impossible by credit; an assertion checks that no push occurs when the buffer is full.

Output:
- out_valid = res_count != 0. out_real/imag = head group lane[ptr], ptr starting at 3.
- On out_valid&out_ready: ptr decrements. At ptr==0 (out_last=1), pop the head and set ptr<=3.
- out_* hold stable while out_valid&!out_ready.
- Pointer wrap on buffer read/write is modulo RES_DEPTH.

busy = fill!=0 | inflight!=0 | res_count!=0.

No arithmetic is performed; SFP words pass bit-exact to and from GEMM.

Test Plan:
- Reset then 4 zero samples on consecutive cycles 0-3, mode=1, out_ready=1 -> gemm_start at cycle 4, gemm_control=1, out_valid cycles 9-12 with all-zero outputs, out_last at cycle 12, busy low at cycle 13.
- Samples r=0x01,0x02,0x03,0x04 (imag 0) into a GEMM stub that echoes input after GEMM_LAT -> gemm_in_real=0x01_02_03_04 packed lane3..0; output order 0x01,0x02,0x03,0x04.
- Stream 3 groups back-to-back with out_ready=0 and RES_DEPTH=2 -> two issues then stall. The third group holds at fill=4 with in_ready=0 and no third gemm_start until the first pop completes. No data is lost once out_ready=1.
- Alternate mode 1,0,1 per group -> gemm_control equals each group's mode during its issue cycle and the following cycle; real GEMM results match the golden radix-4 / dual radix-2 model.
- Random in_valid/out_ready toggling over 200 groups against a scoreboard -> exact order, no duplicates, out_last every 4th sample.
- Assert rst low 2 cycles after an issue -> all outputs reset immediately; no capture of the in-flight group; out_valid stays 0 until new data flows.
